// File: rtl/dpram_frame_reader_if.sv
// Request, RAM read-port and output-stream signals of the frame reader.
// The master modport is the reader engine; the slave modport is its environment.
interface dpram_frame_reader_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              req_vld;
    logic              req_rdy;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_len;
    logic              abort;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd_en;
    logic [DATA_W-1:0] ram_dout;
    logic [DATA_W-1:0] m_dat;
    logic              m_vld;
    logic              m_rdy;
    logic              m_last;
    logic              busy;
    logic              done;

    modport master (
        input  req_vld, req_addr, req_len, abort, ram_dout, m_rdy,
        output req_rdy, ram_addr, ram_rd_en, m_dat, m_vld, m_last, busy, done
    );

    modport slave (
        output req_vld, req_addr, req_len, abort, ram_dout, m_rdy,
        input  req_rdy, ram_addr, ram_rd_en, m_dat, m_vld, m_last, busy, done
    );
endinterface

// File: rtl/dpram_frame_reader.sv
// Read engine for the dual-port frame RAM: streams a requested byte range out on valid/ready.
// Latency: first byte valid 3 cycles after request accept, then 1 byte/cycle sustained.
// Backpressure: reads issue only while buffered plus in-flight bytes fit the output buffer.
module dpram_frame_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int FIFO_D = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    dpram_frame_reader_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_D);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic              done_q, done_d;
    logic              rd_vld_q, rd_last_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    cnt_q;
    logic [DATA_W:0]   mem_q [FIFO_D];

    logic              rd_en;
    logic              fifo_vld;
    logic              push;
    logic              pop;
    logic              head_last;
    logic [PTR_W+1:0]  used;
    logic [DATA_W:0]   head;

    assign head      = mem_q[rd_ptr_q];
    assign fifo_vld  = (cnt_q != '0);
    assign head_last = head[DATA_W];
    assign pop       = fifo_vld & bus.m_rdy;
    assign push      = rd_vld_q & ~bus.abort;
    // Credit: every issued read already owns a buffer slot, so the buffer can never overflow.
    assign used      = (PTR_W+2)'(cnt_q) + (PTR_W+2)'(rd_vld_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        rd_en   = 1'b0;
        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_vld) begin
                        state_d = S_RUN;
                        addr_d  = bus.req_addr;
                        rem_d   = bus.req_len;
                    end
                end
                S_RUN: begin
                    if (used < (PTR_W+2)'(FIFO_D)) begin
                        rd_en  = 1'b1;
                        addr_d = addr_q + ADDR_W'(1);
                        if (rem_q == '0) begin
                            state_d = S_DRAIN;
                        end else begin
                            rem_d = rem_q - ADDR_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && head_last) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            done_q    <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            rd_vld_q  <= rd_en;
            rd_last_q <= rd_en & (rem_q == '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (bus.abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop) begin
                cnt_q <= cnt_q + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {rd_last_q, bus.ram_dout};
    end

    assign bus.req_rdy   = (state_q == S_IDLE) & ~bus.abort;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_rd_en = rd_en;
    assign bus.m_vld     = fifo_vld;
    assign bus.m_dat     = fifo_vld ? head[DATA_W-1:0] : '0;
    assign bus.m_last    = fifo_vld & head_last;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_dpram_frame_reader.sv
// Bench for dpram_frame_reader: RAM model, request-level reference model and per-cycle compare.
module tb_dpram_frame_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dpram_frame_reader_if #(.ADDR_W(12), .DATA_W(8)) bus ();

    dpram_frame_reader #(.ADDR_W(12), .DATA_W(8), .FIFO_D(4)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    logic [7:0] mem [4096];
    always @(posedge clk) bus.ram_dout <= mem[bus.ram_addr];

    int n_chk = 0;
    int n_pass = 0;

    function automatic void chk(input bit ok, input string nm, input int act, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    // reference model state: request-level view of bytes owed and reads allowed
    logic [7:0]  exp_dat[$];
    bit          exp_last[$];
    bit          m_busy = 0;
    logic [11:0] m_addr = '0;
    int          m_left = 0;
    int          m_out = 0;
    bit          first_pending = 0;
    int          acc_cyc = 0;
    int          ncyc = 0;
    bit          prev_stall = 0;
    logic [7:0]  prev_dat = '0;
    bit          exp_done = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [7:0]  beat_dat[$];
    bit          beat_last[$];
    int          beat_cyc[$];
    logic [11:0] rd_addrs[$];
    int          rdy_mode = 0;

    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            chk(bus.ram_addr == '0, "rst_ram_addr", int'(bus.ram_addr), 0);
            chk(bus.ram_rd_en == 1'b0, "rst_rd_en", int'(bus.ram_rd_en), 0);
            chk(bus.m_vld == 1'b0, "rst_m_vld", int'(bus.m_vld), 0);
            chk(bus.m_dat == '0, "rst_m_dat", int'(bus.m_dat), 0);
            chk(bus.m_last == 1'b0, "rst_m_last", int'(bus.m_last), 0);
            chk(bus.busy == 1'b0, "rst_busy", int'(bus.busy), 0);
            chk(bus.done == 1'b0, "rst_done", int'(bus.done), 0);
            exp_dat.delete(); exp_last.delete();
            m_busy = 0; m_left = 0; m_out = 0; first_pending = 0;
            prev_stall = 0; exp_done = 0;
        end else begin
            bit exp_rd;
            chk(bus.done == exp_done, "done", int'(bus.done), int'(exp_done));
            if (bus.done) begin done_cnt++; done_cyc = ncyc; end
            exp_done = 0;
            chk(bus.busy == m_busy, "busy", int'(bus.busy), int'(m_busy));
            chk(bus.req_rdy == (!m_busy && !bus.abort), "req_rdy", int'(bus.req_rdy),
                int'(!m_busy && !bus.abort));
            exp_rd = m_busy && (m_left > 0) && (m_out < 4) && !bus.abort;
            chk(bus.ram_rd_en == exp_rd, "ram_rd_en", int'(bus.ram_rd_en), int'(exp_rd));
            if (bus.ram_rd_en) begin
                chk(bus.ram_addr == m_addr, "ram_addr", int'(bus.ram_addr), int'(m_addr));
                rd_addrs.push_back(bus.ram_addr);
                m_addr = m_addr + 12'd1;
                m_left--;
                m_out++;
            end
            if (bus.m_vld) begin
                if (exp_dat.size() == 0) begin
                    chk(1'b0, "unexpected_beat", int'(bus.m_dat), 0);
                end else begin
                    chk(bus.m_dat == exp_dat[0], "m_dat", int'(bus.m_dat), int'(exp_dat[0]));
                    chk(bus.m_last == exp_last[0], "m_last", int'(bus.m_last), int'(exp_last[0]));
                    if (first_pending) begin
                        chk(ncyc - acc_cyc == 3, "first_latency", ncyc - acc_cyc, 3);
                        first_pending = 0;
                    end
                    if (prev_stall) chk(bus.m_dat == prev_dat, "stall_stable", int'(bus.m_dat), int'(prev_dat));
                    if (bus.m_rdy) begin
                        beat_dat.push_back(bus.m_dat);
                        beat_last.push_back(bus.m_last);
                        beat_cyc.push_back(ncyc);
                        if (exp_last[0] && !bus.abort) begin exp_done = 1; m_busy = 0; end
                        void'(exp_dat.pop_front());
                        void'(exp_last.pop_front());
                        m_out--;
                    end
                end
            end else if (prev_stall) begin
                chk(1'b0, "valid_dropped", 0, 1);
            end
            prev_stall = bus.m_vld && !bus.m_rdy && !bus.abort;
            prev_dat = bus.m_dat;
            if (bus.abort) begin
                exp_dat.delete(); exp_last.delete();
                m_busy = 0; m_left = 0; m_out = 0; first_pending = 0; exp_done = 0;
            end
            if (bus.req_vld && bus.req_rdy) begin
                for (int i = 0; i <= int'(bus.req_len); i++) begin
                    logic [11:0] idx;
                    idx = bus.req_addr + 12'(i);
                    exp_dat.push_back(mem[idx]);
                    exp_last.push_back(i == int'(bus.req_len));
                end
                m_busy = 1; m_addr = bus.req_addr; m_left = int'(bus.req_len) + 1;
                m_out = 0; first_pending = 1; acc_cyc = ncyc;
            end
        end
    end

    initial begin
        bus.m_rdy = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.m_rdy = 1'b1;
                1:       bus.m_rdy = 1'($urandom_range(0, 1));
                default: bus.m_rdy = 1'b0;
            endcase
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] a, input logic [11:0] l);
        bit ok;
        ok = 0;
        bus.req_vld = 1'b1; bus.req_addr = a; bus.req_len = l;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = bus.req_rdy;
            @(posedge clk); #1;
        end
        bus.req_vld = 1'b0;
        if (!ok) chk(1'b0, "timeout_accept", 0, 1);
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk); #1;
            ok = !bus.busy && exp_dat.size() == 0 && !bus.m_vld;
        end
        if (!ok) chk(1'b0, {"timeout_", nm}, 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic clear_obs();
        beat_dat.delete(); beat_last.delete(); beat_cyc.delete(); rd_addrs.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bus.req_vld = 0; bus.req_addr = '0; bus.req_len = '0; bus.abort = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) mem[16 + i] = 8'hA0 + 8'(i);
        mem[12'hFFE] = 8'h5E; mem[12'hFFF] = 8'h5F; mem[0] = 8'h60; mem[1] = 8'h61;
        step(3);
        rst_n = 1'b1;
        step(1);
        chk(bus.req_rdy == 1'b1, "post_rst_req_rdy", int'(bus.req_rdy), 1);
        chk(bus.busy == 1'b0, "post_rst_busy", int'(bus.busy), 0);

        // single short frame at full rate
        rdy_mode = 0; step(1); clear_obs(); d0 = done_cnt;
        send(12'h010, 12'd3);
        wait_idle("t1");
        chk(beat_dat.size() == 4, "t1_count", beat_dat.size(), 4);
        if (beat_dat.size() == 4) begin
            for (int i = 0; i < 4; i++)
                chk(beat_dat[i] == 8'hA0 + 8'(i), "t1_byte", int'(beat_dat[i]), 'hA0 + i);
            chk(beat_cyc[3] - beat_cyc[0] == 3, "t1_back_to_back", beat_cyc[3] - beat_cyc[0], 3);
            chk(beat_cyc[0] - acc_cyc == 3, "t1_latency", beat_cyc[0] - acc_cyc, 3);
            chk(beat_last[3] == 1'b1 && beat_last[0] == 1'b0, "t1_last", int'(beat_last[3]), 1);
            chk(done_cyc == beat_cyc[3] + 1, "t1_done_cyc", done_cyc, beat_cyc[3] + 1);
        end
        chk(done_cnt == d0 + 1, "t1_done_cnt", done_cnt, d0 + 1);

        // address wrap inside one frame
        clear_obs();
        send(12'hFFE, 12'd3);
        wait_idle("t2");
        chk(beat_dat.size() == 4, "t2_count", beat_dat.size(), 4);
        if (beat_dat.size() == 4) begin
            chk(beat_dat[0] == 8'h5E, "t2_b0", int'(beat_dat[0]), 'h5E);
            chk(beat_dat[1] == 8'h5F, "t2_b1", int'(beat_dat[1]), 'h5F);
            chk(beat_dat[2] == 8'h60, "t2_b2", int'(beat_dat[2]), 'h60);
            chk(beat_dat[3] == 8'h61, "t2_b3", int'(beat_dat[3]), 'h61);
        end
        chk(rd_addrs.size() == 4, "t2_reads", rd_addrs.size(), 4);
        if (rd_addrs.size() == 4)
            chk(rd_addrs[2] == 12'h000 && rd_addrs[3] == 12'h001, "t2_wrap", int'(rd_addrs[2]), 0);

        // stall with nothing popped: exactly four reads then hold
        rdy_mode = 2; step(1); clear_obs();
        send(12'h3A0, 12'd15);
        step(10);
        chk(rd_addrs.size() == 4, "t3_credit_stall", rd_addrs.size(), 4);
        rdy_mode = 1;
        wait_idle("t3");
        chk(beat_dat.size() == 16, "t3_count", beat_dat.size(), 16);

        // abort of a long frame with a competing request
        rdy_mode = 0; step(1); d0 = done_cnt;
        send(12'h200, 12'd4095);
        step(4);
        bus.abort = 1'b1; bus.req_vld = 1'b1; bus.req_addr = 12'h100; bus.req_len = 12'd2;
        @(negedge clk);
        chk(bus.req_rdy == 1'b0, "t4_abort_blocks_req", int'(bus.req_rdy), 0);
        @(posedge clk); #1;
        bus.abort = 1'b0; clear_obs();
        @(negedge clk);
        chk(bus.busy == 1'b0, "t4_idle_after_abort", int'(bus.busy), 0);
        chk(bus.m_vld == 1'b0, "t4_m_vld_flushed", int'(bus.m_vld), 0);
        chk(bus.req_rdy == 1'b1, "t4_req_rdy_next", int'(bus.req_rdy), 1);
        @(posedge clk); #1;
        bus.req_vld = 1'b0;
        wait_idle("t4");
        chk(beat_dat.size() == 3, "t4_count", beat_dat.size(), 3);
        if (beat_dat.size() == 3)
            for (int i = 0; i < 3; i++)
                chk(beat_dat[i] == mem[12'h100 + 12'(i)], "t4_byte", int'(beat_dat[i]),
                    int'(mem[12'h100 + 12'(i)]));
        chk(done_cnt == d0 + 1, "t4_done_cnt", done_cnt, d0 + 1);

        // single byte, then reset in the middle of a frame
        clear_obs(); d0 = done_cnt;
        send(12'h777, 12'd0);
        wait_idle("t5a");
        chk(beat_dat.size() == 1, "t5_count", beat_dat.size(), 1);
        if (beat_dat.size() == 1) chk(beat_last[0] == 1'b1, "t5_last", int'(beat_last[0]), 1);
        chk(done_cnt == d0 + 1, "t5_done", done_cnt, d0 + 1);
        send(12'h400, 12'd100);
        step(8);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        clear_obs(); d0 = done_cnt;
        step(6);
        chk(beat_dat.size() == 0, "t5_no_beats_after_rst", beat_dat.size(), 0);
        chk(done_cnt == d0, "t5_no_done_after_rst", done_cnt, d0);
        chk(bus.busy == 1'b0, "t5_busy_after_rst", int'(bus.busy), 0);

        // randomized traffic against the model
        for (int r = 0; r < 30; r++) begin
            rdy_mode = int'($urandom_range(0, 1));
            send(12'($urandom), 12'($urandom_range(0, 40)));
            if ($urandom_range(0, 5) == 0) begin
                step(int'($urandom_range(0, 20)));
                bus.abort = 1'b1;
                step(1);
                bus.abort = 1'b0;
            end
            wait_idle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
